// File: rtl/pwm_duty_ctrl.sv
// Button-driven PWM duty controller: synchronize, debounce, auto-repeat,
// saturating duty register, stretched step indicators and a 1 Hz square wave.
module pwm_duty_ctrl #(
   parameter int WIDTH      = 4,
   parameter int DUTY_MAX   = 10,
   parameter int DUTY_RST   = 5,
   parameter int DEB_CYC    = 8,
   parameter int REP_DELAY  = 16,
   parameter int REP_PERIOD = 4,
   parameter int LED_CYC    = 6,
   parameter int HALF_SEC   = 500
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             btn_incrPWM,
   input  logic             btn_decrPWM,
   output logic [WIDTH-1:0] duty,
   output logic             duty_upd,
   output logic             inled,
   output logic             deled,
   output logic             sat,
   output logic             clock_1hz
);

   localparam int DCW = $clog2(DEB_CYC + 1);
   localparam int RMX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
   localparam int RCW = $clog2(RMX + 1);
   localparam int LCW = $clog2(LED_CYC + 1);
   localparam int HCW = (HALF_SEC > 1) ? $clog2(HALF_SEC) : 1;
   localparam logic [WIDTH-1:0] DMAX  = WIDTH'(DUTY_MAX);
   localparam logic [WIDTH-1:0] DINIT =
      (DUTY_RST > DUTY_MAX) ? WIDTH'(DUTY_MAX) : WIDTH'(DUTY_RST);

   typedef enum logic [1:0] {IDLE, HOLD_INC, HOLD_DEC, BLOCK} state_t;

   // bit 0 = increment button, bit 1 = decrement button
   logic [1:0]     raw;
   logic [1:0]     s1_q, s2_q, lvl_q;
   logic [DCW-1:0] dcnt_q [2];

   state_t           state_q;
   logic [RCW-1:0]   rcnt_q, rcnt_dec;
   logic [WIDTH-1:0] duty_q, duty_d, up_d, dn_d;
   logic             upd_q, inc_step, dec_step, chg;
   logic [LCW-1:0]   in_cnt_q, de_cnt_q;
   logic [HCW-1:0]   hcnt_q;
   logic             clk1_q;

   assign raw = {btn_decrPWM, btn_incrPWM};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_q      <= '0;
         s2_q      <= '0;
         lvl_q     <= '0;
         dcnt_q[0] <= '0;
         dcnt_q[1] <= '0;
      end else begin
         s1_q <= raw;
         s2_q <= s1_q;
         for (int i = 0; i < 2; i++) begin
            if (s2_q[i] == lvl_q[i]) begin
               dcnt_q[i] <= '0;
            end else if (dcnt_q[i] == DCW'(DEB_CYC - 1)) begin
               lvl_q[i]  <= s2_q[i];
               dcnt_q[i] <= '0;
            end else begin
               dcnt_q[i] <= dcnt_q[i] + 1'b1;
            end
         end
      end
   end

   assign rcnt_dec = rcnt_q - 1'b1;
   assign up_d     = (duty_q >= DMAX) ? DMAX : duty_q + 1'b1;
   assign dn_d     = (duty_q == '0) ? '0 : duty_q - 1'b1;

   always_comb begin
      inc_step = 1'b0;
      dec_step = 1'b0;
      unique case (state_q)
         IDLE: begin
            inc_step = lvl_q[0] & ~lvl_q[1];
            dec_step = lvl_q[1] & ~lvl_q[0];
         end
         HOLD_INC: inc_step = lvl_q[0] & ~lvl_q[1] & (rcnt_dec == '0);
         HOLD_DEC: dec_step = lvl_q[1] & ~lvl_q[0] & (rcnt_dec == '0);
         BLOCK:    ;
      endcase
   end

   always_comb begin
      duty_d = duty_q;
      if (inc_step) duty_d = up_d;
      else if (dec_step) duty_d = dn_d;
   end

   assign chg = (duty_d != duty_q);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         rcnt_q  <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (&lvl_q) begin
                  state_q <= BLOCK;
               end else if (lvl_q[0]) begin
                  state_q <= HOLD_INC;
                  rcnt_q  <= RCW'(REP_DELAY);
               end else if (lvl_q[1]) begin
                  state_q <= HOLD_DEC;
                  rcnt_q  <= RCW'(REP_DELAY);
               end
            end
            HOLD_INC: begin
               if (!lvl_q[0]) state_q <= IDLE;
               else if (lvl_q[1]) state_q <= BLOCK;
               else rcnt_q <= (rcnt_dec == '0) ? RCW'(REP_PERIOD) : rcnt_dec;
            end
            HOLD_DEC: begin
               if (!lvl_q[1]) state_q <= IDLE;
               else if (lvl_q[0]) state_q <= BLOCK;
               else rcnt_q <= (rcnt_dec == '0) ? RCW'(REP_PERIOD) : rcnt_dec;
            end
            BLOCK: begin
               if (lvl_q == 2'b00) state_q <= IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         duty_q   <= DINIT;
         upd_q    <= 1'b0;
         in_cnt_q <= '0;
         de_cnt_q <= '0;
      end else begin
         duty_q <= duty_d;
         upd_q  <= chg;
         if (chg && inc_step) in_cnt_q <= LCW'(LED_CYC);
         else if (in_cnt_q != '0) in_cnt_q <= in_cnt_q - 1'b1;
         if (chg && dec_step) de_cnt_q <= LCW'(LED_CYC);
         else if (de_cnt_q != '0) de_cnt_q <= de_cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hcnt_q <= '0;
         clk1_q <= 1'b0;
      end else if (hcnt_q == HCW'(HALF_SEC - 1)) begin
         hcnt_q <= '0;
         clk1_q <= ~clk1_q;
      end else begin
         hcnt_q <= hcnt_q + 1'b1;
      end
   end

   assign duty      = duty_q;
   assign duty_upd  = upd_q;
   assign inled     = (in_cnt_q != '0);
   assign deled     = (de_cnt_q != '0);
   assign sat       = (duty_q == '0) || (duty_q == DMAX);
   assign clock_1hz = clk1_q;

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Bench for pwm_duty_ctrl: vector table, hand sequences and random
// button activity checked every cycle against an event-level model.
module tb_pwm_duty_ctrl;

   localparam int WIDTH = 4;
   localparam int DMAX  = 10;
   localparam int DRST  = 5;
   localparam int DEB   = 8;
   localparam int RDLY  = 16;
   localparam int RPER  = 4;
   localparam int LED   = 6;
   localparam int HALF  = 500;

   logic             clk = 1'b0;
   logic             reset;
   logic             btn_incrPWM, btn_decrPWM;
   logic [WIDTH-1:0] duty;
   logic             duty_upd, inled, deled, sat, clock_1hz;

   pwm_duty_ctrl #(
      .WIDTH(WIDTH), .DUTY_MAX(DMAX), .DUTY_RST(DRST), .DEB_CYC(DEB),
      .REP_DELAY(RDLY), .REP_PERIOD(RPER), .LED_CYC(LED), .HALF_SEC(HALF)
   ) dut (
      .clk(clk), .reset(reset),
      .btn_incrPWM(btn_incrPWM), .btn_decrPWM(btn_decrPWM),
      .duty(duty), .duty_upd(duty_upd), .inled(inled), .deled(deled),
      .sat(sat), .clock_1hz(clock_1hz)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // model state: raw history, synchronized samples, debounced levels
   int   hi[$], hd[$], si[$], sd[$];
   logic li, ld;
   int   mode, el, mduty, last_inc, last_dec, en, c1;
   logic mupd;

   localparam int M_IDLE = 0, M_INC = 1, M_DEC = 2, M_BLK = 3;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, en);
      end
   endtask

   task automatic m_reset();
      hi = '{0, 0};
      hd = '{0, 0};
      si.delete();
      sd.delete();
      li = 0; ld = 0;
      mode = M_IDLE; el = 0;
      mduty = DRST; mupd = 0;
      last_inc = -100000; last_dec = -100000;
      c1 = 0;
   endtask

   function automatic logic flips(input int q[$], input logic lv);
      if (q.size() < DEB) return 1'b0;
      for (int k = q.size() - DEB; k < q.size(); k++)
         if (q[k] == int'(lv)) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic rep_due(input int e);
      return (e >= RDLY) && (((e - RDLY) % RPER) == 0);
   endfunction

   task automatic m_edge(input logic ri, input logic rd);
      int step, nd;
      en++;
      if (reset) begin
         m_reset();
         return;
      end
      c1++;
      hi.push_back(int'(ri));
      hd.push_back(int'(rd));
      si.push_back(hi[hi.size() - 3]);
      sd.push_back(hd[hd.size() - 3]);
      if (hi.size() > 8) hi.delete(0);
      if (hd.size() > 8) hd.delete(0);
      if (si.size() > 2 * DEB) si.delete(0);
      if (sd.size() > 2 * DEB) sd.delete(0);
      step = 0;
      case (mode)
         M_IDLE:
            if (li && ld) mode = M_BLK;
            else if (li) begin step = 1; mode = M_INC; el = 0; end
            else if (ld) begin step = -1; mode = M_DEC; el = 0; end
         M_INC:
            if (!li) mode = M_IDLE;
            else if (ld) mode = M_BLK;
            else begin el++; if (rep_due(el)) step = 1; end
         M_DEC:
            if (!ld) mode = M_IDLE;
            else if (li) mode = M_BLK;
            else begin el++; if (rep_due(el)) step = -1; end
         default:
            if (!li && !ld) mode = M_IDLE;
      endcase
      nd = mduty + step;
      if (nd < 0) nd = 0;
      if (nd > DMAX) nd = DMAX;
      mupd = (nd != mduty);
      if (mupd && step > 0) last_inc = en;
      if (mupd && step < 0) last_dec = en;
      mduty = nd;
      if (flips(si, li)) li = ~li;
      if (flips(sd, ld)) ld = ~ld;
   endtask

   task automatic check_all();
      chk("duty", int'(duty), mduty);
      chk("duty_upd", int'(duty_upd), int'(mupd));
      chk("inled", int'(inled), int'((en - last_inc) < LED));
      chk("deled", int'(deled), int'((en - last_dec) < LED));
      chk("sat", int'(sat), int'(mduty == 0 || mduty == DMAX));
      chk("clock_1hz", int'(clock_1hz), (c1 / HALF) % 2);
   endtask

   task automatic cyc(input logic i, input logic d);
      btn_incrPWM = i;
      btn_decrPWM = d;
      @(posedge clk);
      m_edge(i, d);
      @(negedge clk);
      check_all();
   endtask

   typedef struct {
      logic inc;
      logic dec;
      int   n;
      logic chk;
      int   exp_duty;
      logic exp_sat;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic i, input logic d, input int n,
                      input logic c, input int ed, input logic es);
      vec_t v;
      v.inc = i; v.dec = d; v.n = n;
      v.chk = c; v.exp_duty = ed; v.exp_sat = es;
      tbl.push_back(v);
   endtask

   initial begin
      int n_upd, n_inl, n_del, len;
      logic ri, rd;

      add(0, 1, 40, 1, 0, 1);
      add(0, 0, 20, 1, 0, 1);
      add(1, 0, 12, 1, 1, 0);
      add(0, 0, 20, 1, 1, 0);
      add(1, 1, 30, 1, 1, 0);
      add(0, 0, 20, 1, 1, 0);
      add(1, 0, 12, 1, 2, 0);
      add(0, 0, 20, 1, 2, 0);
      for (int k = 0; k < 4; k++) begin
         add(1, 0, 3, 0, 0, 0);
         add(0, 0, 3, 0, 0, 0);
      end
      add(0, 0, 20, 1, 2, 0);
      add(1, 0, 60, 1, 10, 1);
      add(0, 0, 20, 1, 10, 1);
      add(1, 0, 12, 1, 10, 1);
      add(0, 0, 20, 1, 10, 1);
      add(0, 1, 12, 1, 9, 0);
      add(0, 0, 20, 1, 9, 0);

      en = 0;
      reset = 1'b1;
      btn_incrPWM = 1'b0;
      btn_decrPWM = 1'b0;
      m_reset();
      #1;
      chk("rst_duty", int'(duty), DRST);
      chk("rst_upd", int'(duty_upd), 0);
      chk("rst_leds", int'({inled, deled}), 0);
      chk("rst_clk1hz", int'(clock_1hz), 0);
      cyc(0, 0);
      cyc(0, 0);
      reset = 1'b0;

      // single press: exact latency, one strobe, six LED cycles
      n_upd = 0; n_inl = 0; n_del = 0;
      for (int k = 1; k <= 30; k++) begin
         cyc(k <= 12, 0);
         if (k == 10) chk("lat_before", int'(duty), 5);
         if (k == 11) chk("lat_step", int'(duty), 6);
         n_upd += int'(duty_upd);
         n_inl += int'(inled);
         n_del += int'(deled);
      end
      chk("single_upd_pulses", n_upd, 1);
      chk("single_inled_cycles", n_inl, LED);
      chk("single_deled_cycles", n_del, 0);
      chk("single_duty", int'(duty), 6);

      reset = 1'b1;
      cyc(0, 0);
      reset = 1'b0;

      foreach (tbl[t]) begin
         for (int k = 0; k < tbl[t].n; k++) cyc(tbl[t].inc, tbl[t].dec);
         if (tbl[t].chk) begin
            chk($sformatf("tbl%0d_duty", t), int'(duty), tbl[t].exp_duty);
            chk($sformatf("tbl%0d_sat", t), int'(sat), int'(tbl[t].exp_sat));
         end
      end

      // reset in the middle of a hold, button kept pressed throughout
      for (int k = 0; k < 20; k++) cyc(1, 0);
      reset = 1'b1;
      #1;
      m_reset();
      chk("midrst_duty", int'(duty), DRST);
      chk("midrst_clk1hz", int'(clock_1hz), 0);
      chk("midrst_upd", int'(duty_upd), 0);
      cyc(1, 0);
      cyc(1, 0);
      reset = 1'b0;
      for (int k = 1; k <= 520; k++) begin
         cyc(1, 0);
         if (k == 10) chk("repress_before", int'(duty), 5);
         if (k == 11) chk("repress_step", int'(duty), 6);
         if (k == 499) chk("clk1hz_low", int'(clock_1hz), 0);
         if (k == 500) chk("clk1hz_high", int'(clock_1hz), 1);
      end

      for (int k = 0; k < 6; k++) cyc(0, 0);
      for (int n = 0; n < 2500; n += len) begin
         ri = 1'($urandom_range(0, 1));
         rd = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
         len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 9)
                                           : $urandom_range(10, 60);
         for (int k = 0; k < len; k++) cyc(ri, rd);
         if ($urandom_range(0, 40) == 0) begin
            reset = 1'b1;
            cyc(ri, rd);
            reset = 1'b0;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pwm_duty_ctrl.md
PWM_DUTY_CTRL -- requirements
Module: pwm_duty_ctrl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  WIDTH, 4, duty word width
  DUTY_MAX, 10, upper duty limit
  DUTY_RST, 5, duty value after reset
  DEB_CYC, 8, stable-sample count to accept a button level
  REP_DELAY, 16, cycles held before first auto-repeat
  REP_PERIOD, 4, cycles between auto-repeat steps
  LED_CYC, 6, LED stretch length in cycles
  HALF_SEC, 500, cycles per clock_1hz half period
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  in  1  single clock; all state on rising edge
  reset  in  1  asynchronous, active-high reset
  btn_incrPWM  in  1  raw increment button, asynchronous, active-high
  btn_decrPWM  in  1  raw decrement button, asynchronous, active-high
  duty  out  WIDTH  duty setting to the PWM core, registered
  duty_upd  out  1  one-cycle strobe when duty changes
  inled  out  1  increment indicator, stretched
  deled  out  1  decrement indicator, stretched
  sat  out  1  high while duty==0 or duty==DUTY_MAX
  clock_1hz  out  1  square wave, period 2*HALF_SEC cycles

Function
REQ-003 Each button SHALL pass a 2-flop synchronizer, then a debouncer updating its debounced level only after DEB_CYC consecutive equal synchronized samples differing from the current level.
REQ-004 Latency from a clean raw edge to the debounced edge SHALL be exactly 2+DEB_CYC cycles; a glitch shorter than DEB_CYC samples SHALL cause no change.
REQ-005 Control FSM SHALL have states IDLE, HOLD_INC, HOLD_DEC, BLOCK.
REQ-006 IDLE: exactly one debounced button high -> apply one step in that direction, load repeat counter with REP_DELAY, go HOLD_INC/HOLD_DEC; both high -> BLOCK, no step.
REQ-007 HOLD_x: own button low -> IDLE; other button high -> BLOCK, no step; else decrement counter, at zero apply one step and reload REP_PERIOD.
REQ-008 BLOCK: stay until both debounced buttons low, then IDLE; no steps in BLOCK.
REQ-009 Step SHALL be +1/-1 saturating in [0, DUTY_MAX]; a step at a limit SHALL leave duty unchanged.
REQ-010 duty SHALL update in the cycle after the step decision; duty_upd SHALL pulse for that one cycle only if the value changed.
REQ-011 inled/deled SHALL go high the cycle duty_upd asserts for their direction and stay high LED_CYC cycles, restarting on each new step; a saturated (no-change) step SHALL not light them.
REQ-012 sat SHALL be combinational from the duty register.
REQ-013 clock_1hz SHALL toggle when a free-running counter reaches HALF_SEC-1, then wrap to 0; independent of FSM.
REQ-014 Values of DUTY_RST above DUTY_MAX SHALL be clamped to DUTY_MAX at reset.

Reset
REQ-015 On reset high, asynchronously: duty=DUTY_RST, duty_upd=0, inled=0, deled=0, clock_1hz=0, FSM=IDLE, synchronizers/debounced levels=0, all counters=0.
REQ-016 Reset asserted mid-hold SHALL abort the hold; after release a still-held button SHALL be treated as a new press after 2+DEB_CYC cycles.

Verification
REQ-017 Single press: reset, hold btn_incrPWM 12 cycles -> one step, duty 5->6, duty_upd one pulse, inled high 6 cycles, deled 0.
REQ-018 Auto-repeat: hold btn_decrPWM 40 cycles from duty 5 -> steps at debounce+0, +16, +20, +24 ... ; duty 5->4->3->2->1->0, then stays 0, sat=1, no further duty_upd.
REQ-019 Saturation: from duty 10 press increment -> duty stays 10, no duty_upd, inled stays 0, sat=1.
REQ-020 Simultaneous: both buttons raised same cycle, held 30 cycles -> FSM BLOCK, duty unchanged; release both, press increment -> normal single step.
REQ-021 Bounce: 3-cycle pulses on btn_incrPWM separated by 3 low cycles -> no step; reset pulse during a hold -> duty=5 immediately, clock_1hz=0, counter restarts, toggles every 500 cycles thereafter.
